// File: rtl/lcd_init_seq.sv
// lcd_init_seq: HD44780 power-on initialisation sequencer.
// It walks the power wait, three wake transfers, the optional 4-bit switch and
// five configuration commands. It drives the strobe/timing module through
// start_timing/timing_done, then parks in DONE so the normal write path can
// take over.
// Optional feature: define LCD_INIT_REINIT_EN to allow reinit_req in DONE to
// rerun the sequence from WAKE1 without the power wait.
module lcd_init_seq #(
    parameter int CLK_HZ     = 25000000,
    parameter bit BUS_8BIT   = 1'b0,
    parameter bit TWO_LINE   = 1'b1,
    parameter bit FONT_5X10  = 1'b0,
    parameter bit ENTRY_INC  = 1'b1,
    parameter bit CURSOR_ON  = 1'b0,
    parameter bit BLINK_ON   = 1'b0,
    parameter int T_POWER_US = 15000,
    parameter int T_WAKE1_US = 4100,
    parameter int T_WAKE2_US = 100,
    parameter int T_CMD_US   = 40,
    parameter int T_CLEAR_US = 1640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timing_done,
    input  logic       reinit_req,
    output logic       start_timing,
    output logic [7:0] data_out,
    output logic       rs_out,
    output logic       init_active,
    output logic       init_done,
    output logic [3:0] step
);

    // Wait times in clock cycles (cycles per microsecond is truncated first).
    localparam int CYC_PER_US = CLK_HZ / 1000000;
    localparam int D_POWER    = CYC_PER_US * T_POWER_US;
    localparam int D_WAKE1    = CYC_PER_US * T_WAKE1_US;
    localparam int D_WAKE2    = CYC_PER_US * T_WAKE2_US;
    localparam int D_CMD      = CYC_PER_US * T_CMD_US;
    localparam int D_CLEAR    = CYC_PER_US * T_CLEAR_US;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int D_MAX = max2(max2(D_POWER, D_WAKE1), max2(max2(D_WAKE2, D_CMD), D_CLEAR));
    localparam int CNT_W = $clog2(D_MAX) + 1;

    // Step indices as exposed on the step port.
    localparam logic [3:0] STEP_PWR   = 4'd0;
    localparam logic [3:0] STEP_WAKE1 = 4'd1;
    localparam logic [3:0] STEP_WAKE2 = 4'd2;
    localparam logic [3:0] STEP_WAKE3 = 4'd3;
    localparam logic [3:0] STEP_SET4  = 4'd4;
    localparam logic [3:0] STEP_FSET  = 4'd5;
    localparam logic [3:0] STEP_DOFF  = 4'd6;
    localparam logic [3:0] STEP_CLR   = 4'd7;
    localparam logic [3:0] STEP_ENTRY = 4'd8;
    localparam logic [3:0] STEP_DON   = 4'd9;
    localparam logic [3:0] STEP_DONE  = 4'd10;

    // Transfer values. Wake values are already bus-width specific; the
    // command bytes are split into nibbles later when the bus is 4 bits wide.
    localparam logic [7:0] WAKE_BYTE  = BUS_8BIT ? 8'h30 : 8'h03;
    localparam logic [7:0] SET4_BYTE  = 8'h02;
    localparam logic [7:0] FSET_BYTE  = {3'b001, BUS_8BIT, TWO_LINE, FONT_5X10, 2'b00};
    localparam logic [7:0] DOFF_BYTE  = 8'h08;
    localparam logic [7:0] CLR_BYTE   = 8'h01;
    localparam logic [7:0] ENTRY_BYTE = {5'b00000, 1'b1, ENTRY_INC, 1'b0};
    localparam logic [7:0] DON_BYTE   = {4'b0000, 2'b11, CURSOR_ON, BLINK_ON};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWR,
        S_SEND,
        S_WAIT_XFER,
        S_DELAY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic             nib_q, nib_d;       // 1 while sending the low nibble
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;

    // Per-step command byte and post-step wait (minus one, as loaded into cnt).
    logic [7:0]       cmd_tab   [16];
    logic [CNT_W-1:0] delay_tab [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_step_tab
            localparam int D_STEP =
                (gi == int'(STEP_WAKE1)) ? D_WAKE1 :
                (gi == int'(STEP_WAKE2)) ? D_WAKE2 :
                (gi == int'(STEP_CLR))   ? D_CLEAR : D_CMD;
            localparam logic [7:0] CMD_STEP =
                (gi >= int'(STEP_WAKE1) && gi <= int'(STEP_WAKE3)) ? WAKE_BYTE :
                (gi == int'(STEP_SET4))  ? SET4_BYTE  :
                (gi == int'(STEP_FSET))  ? FSET_BYTE  :
                (gi == int'(STEP_DOFF))  ? DOFF_BYTE  :
                (gi == int'(STEP_CLR))   ? CLR_BYTE   :
                (gi == int'(STEP_ENTRY)) ? ENTRY_BYTE :
                (gi == int'(STEP_DON))   ? DON_BYTE   : 8'h00;
            assign cmd_tab[gi]   = CMD_STEP;
            assign delay_tab[gi] = CNT_W'(D_STEP - 1);
        end
    endgenerate

    // Step-derived helpers: following step, its first transfer value, the low
    // nibble of the current command, and whether the current step is a pair.
    logic [3:0] step_nx;
    logic [7:0] nx_cmd;
    logic [7:0] nx_first;
    logic [7:0] cur_low;
    logic       two_xfer;

    // Derive the next step and the values it will put on the bus.
    always_comb begin
        step_nx  = (BUS_8BIT && step_q == STEP_WAKE3) ? STEP_FSET : step_q + 4'd1;
        nx_cmd   = cmd_tab[step_nx];
        nx_first = (!BUS_8BIT && step_nx >= STEP_FSET) ? {4'h0, nx_cmd[7:4]} : nx_cmd;
        cur_low  = {4'h0, cmd_tab[step_q][3:0]};
        two_xfer = !BUS_8BIT && (step_q >= STEP_FSET) && (step_q <= STEP_DON);
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        nib_d   = nib_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                // First cycle out of reset: begin the power-on wait.
                state_d = S_PWR;
                step_d  = STEP_PWR;
                cnt_d   = CNT_W'(D_POWER - 1);
            end
            S_PWR: begin
                if (cnt_q == '0) begin
                    state_d = S_SEND;
                    step_d  = STEP_WAKE1;
                    nib_d   = 1'b0;
                    data_d  = WAKE_BYTE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SEND: begin
                state_d = S_WAIT_XFER;
            end
            S_WAIT_XFER: begin
                if (timing_done) begin
                    if (two_xfer && !nib_q) begin
                        // Low nibble goes out straight after the high one.
                        state_d = S_SEND;
                        nib_d   = 1'b1;
                        data_d  = cur_low;
                    end else if (step_q == STEP_DON) begin
                        // Last command: no settle delay before handing over.
                        state_d = S_DONE;
                        step_d  = STEP_DONE;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = delay_tab[step_q];
                    end
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = S_SEND;
                    step_d  = step_nx;
                    nib_d   = 1'b0;
                    data_d  = nx_first;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
`ifdef LCD_INIT_REINIT_EN
                // Rerun from WAKE1; the panel is already powered.
                if (reinit_req) begin
                    state_d = S_SEND;
                    step_d  = STEP_WAKE1;
                    nib_d   = 1'b0;
                    data_d  = WAKE_BYTE;
                end
`else
                // DONE is terminal until reset; the request has no effect.
                if (reinit_req) begin
                    state_d = S_DONE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= STEP_PWR;
            nib_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            nib_q   <= nib_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign start_timing = (state_q == S_SEND);
    assign data_out     = data_q;
    assign rs_out       = 1'b0;
    assign init_active  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign init_done    = (state_q == S_DONE);
    assign step         = step_q;

endmodule
